// File: rtl/ahb_crypto_slave_p.sv
// rtl/ahb_crypto_slave_p.sv - AHB-Lite register slave for an AES engine: key, command, FIFO data ports.
// Address phase is decoded into a transfer kind; the data phase stalls on FIFO flags.
module ahb_crypto_slave_p #(
  parameter int KEY_WORDS = 4,
  parameter int STATUS_W  = 8
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSELx,
  input  logic                    HWRITE,
  input  logic [31:0]             HADDR,
  input  logic [1:0]              HTRANS,
  input  logic [2:0]              HSIZE,
  input  logic [31:0]             HWDATA,
  input  logic [STATUS_W-1:0]     status,
  input  logic [31:0]             data_out,
  input  logic                    rcv_fifo_full,
  input  logic                    rcv_fifo_empty,
  input  logic                    tx_fifo_empty,
  output logic [31:0]             HRDATA,
  output logic                    HREADY,
  output logic                    HRESP,
  output logic [31:0]             rcv_data,
  output logic                    rcv_enq_word,
  output logic                    tx_deq_word,
  output logic [32*KEY_WORDS-1:0] key_out,
  output logic                    key_load,
  output logic                    is_encrypt_pulse,
  output logic                    is_decrypt_pulse
);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_t;
  typedef enum logic [2:0] {K_NONE, K_STATUS, K_ENC, K_DEC, K_KEY, K_DIN, K_DOUT} kind_t;

  localparam logic [7:0] KEY_LAST = 8'(16 + 4 * (KEY_WORDS - 1));

  state_t      r_state;
  state_t      w_next;
  kind_t       r_kind;
  kind_t       w_kind;
  logic        w_err;
  logic [2:0]  w_kidx;
  logic [2:0]  r_kidx;
  logic [7:0]  w_lo;
  logic        w_accept;
  logic        w_in_data;
  logic        w_stall;
  logic        w_done;
  logic        w_ready;
  logic [31:0] w_status_ext;
  logic [31:0] r_key [KEY_WORDS];
  logic        r_key_load;
  logic        r_enc;
  logic        r_dec;

  // Address-phase decode: kind of access, or error for anything not legal.
  always_comb begin
    w_kind = K_NONE;
    w_err  = 1'b0;
    w_lo   = HADDR[7:0];
    // key window starts at word offset 4 of the low address byte, so index wraps mod 8
    w_kidx = HADDR[4:2] - 3'd4;
    if ((HADDR[31:8] != 24'd0) || (HADDR[1:0] != 2'd0) || (HSIZE != 3'd2)) begin
      w_err = 1'b1;
    end else if (w_lo == 8'h00) begin
      w_err  = HWRITE;
      w_kind = HWRITE ? K_NONE : K_STATUS;
    end else if (w_lo == 8'h04) begin
      w_err  = !HWRITE;
      w_kind = HWRITE ? K_ENC : K_NONE;
    end else if (w_lo == 8'h08) begin
      w_err  = !HWRITE;
      w_kind = HWRITE ? K_DEC : K_NONE;
    end else if ((w_lo >= 8'h10) && (w_lo <= KEY_LAST)) begin
      w_err  = !HWRITE;
      w_kind = HWRITE ? K_KEY : K_NONE;
    end else if ((w_lo >= 8'h40) && (w_lo <= 8'h4C)) begin
      w_err  = !HWRITE;
      w_kind = HWRITE ? K_DIN : K_NONE;
    end else if ((w_lo >= 8'h80) && (w_lo <= 8'h8C)) begin
      w_err  = HWRITE;
      w_kind = HWRITE ? K_NONE : K_DOUT;
    end else begin
      w_err = 1'b1;
    end
  end

  always_comb begin
    w_in_data = (r_state == S_DATA) || (r_state == S_WAIT);
    w_stall   = w_in_data && (((r_kind == K_KEY)  && !rcv_fifo_empty) ||
                              ((r_kind == K_DIN)  &&  rcv_fifo_full)  ||
                              ((r_kind == K_DOUT) &&  tx_fifo_empty));
    w_done    = w_in_data && !w_stall;
    w_ready   = !(w_stall || (r_state == S_ERR1));
    w_accept  = HSELx && ((HTRANS == 2'b10) || (HTRANS == 2'b11)) && w_ready;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_ERR2: begin
        if (w_accept) w_next = w_err ? S_ERR1 : S_DATA;
        else          w_next = S_IDLE;
      end
      S_DATA, S_WAIT: begin
        if (w_stall)       w_next = S_WAIT;
        else if (w_accept) w_next = w_err ? S_ERR1 : S_DATA;
        else               w_next = S_IDLE;
      end
      S_ERR1:  w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_status_ext                 = '0;
    w_status_ext[STATUS_W-1:0]   = status;
    HREADY                       = w_ready;
    HRESP                        = (r_state == S_ERR1) || (r_state == S_ERR2);
    HRDATA                       = '0;
    if (w_done && (r_kind == K_STATUS))    HRDATA = w_status_ext;
    else if (w_done && (r_kind == K_DOUT)) HRDATA = data_out;
    rcv_enq_word                 = w_done && (r_kind == K_DIN);
    rcv_data                     = (w_done && (r_kind == K_DIN)) ? HWDATA : '0;
    tx_deq_word                  = w_done && (r_kind == K_DOUT);
    key_load                     = r_key_load;
    is_encrypt_pulse             = r_enc;
    is_decrypt_pulse             = r_dec;
  end

  always_comb begin
    key_out = '0;
    for (int i = 0; i < KEY_WORDS; i++) begin
      key_out[32*(KEY_WORDS-1-i) +: 32] = r_key[i];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= S_IDLE;
      r_kind     <= K_NONE;
      r_kidx     <= '0;
      r_key_load <= 1'b0;
      r_enc      <= 1'b0;
      r_dec      <= 1'b0;
      for (int i = 0; i < KEY_WORDS; i++) r_key[i] <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_kind <= w_err ? K_NONE : w_kind;
        r_kidx <= w_kidx;
      end
      r_key_load <= w_done && (r_kind == K_KEY) && (r_kidx == 3'(KEY_WORDS - 1));
      r_enc      <= w_done && (r_kind == K_ENC);
      r_dec      <= w_done && (r_kind == K_DEC);
      for (int i = 0; i < KEY_WORDS; i++) begin
        if (w_done && (r_kind == K_KEY) && (r_kidx == 3'(i))) r_key[i] <= HWDATA;
      end
    end
  end

endmodule

// File: tb/tb_ahb_crypto_slave_p.sv
// tb/tb_ahb_crypto_slave_p.sv - directed bench for ahb_crypto_slave_p with queue scoreboard.
module tb_ahb_crypto_slave_p;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic         HSELx, HWRITE;
  logic [31:0]  HADDR, HWDATA;
  logic [1:0]   HTRANS;
  logic [2:0]   HSIZE;
  logic [7:0]   status;
  logic [31:0]  data_out;
  logic         rcv_fifo_full, rcv_fifo_empty, tx_fifo_empty;
  logic [31:0]  HRDATA, rcv_data;
  logic         HREADY, HRESP, rcv_enq_word, tx_deq_word;
  logic [127:0] key_out;
  logic         key_load, is_encrypt_pulse, is_decrypt_pulse;

  always #5 HCLK = ~HCLK;

  ahb_crypto_slave_p #(.KEY_WORDS(4), .STATUS_W(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(HSELx), .HWRITE(HWRITE),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .status(status), .data_out(data_out),
    .rcv_fifo_full(rcv_fifo_full), .rcv_fifo_empty(rcv_fifo_empty), .tx_fifo_empty(tx_fifo_empty),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .rcv_data(rcv_data), .rcv_enq_word(rcv_enq_word), .tx_deq_word(tx_deq_word),
    .key_out(key_out), .key_load(key_load),
    .is_encrypt_pulse(is_encrypt_pulse), .is_decrypt_pulse(is_decrypt_pulse)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cnt_enq = 0, cnt_deq = 0, cnt_kl = 0, cnt_enc = 0, cnt_dec = 0;
  int enc_cyc = 0, dec_cyc = 0;
  int enq_cyc[$];
  logic [31:0] din_q[$];
  logic [31:0] rd_q[$];
  logic [1:0]  rr_log[$];

  logic [31:0] t_addr[16], t_data[16], t_exp[16];
  logic [2:0]  t_size[16];
  bit          t_wr[16], t_err[16];
  int          stall_idx = -1, stall_left = 0, stall_sel = 0;
  int          last_waits = 0;
  bit          hold_chk = 0;
  logic [31:0] hold_exp = '0;
  int          c0, c1, c2, c3, c4;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge HCLK) cyc++;

  always @(negedge HCLK) begin
    if (rcv_enq_word === 1'b1) begin
      cnt_enq++;
      enq_cyc.push_back(cyc);
      chk("din_expected", 256'(din_q.size() != 0), 256'(1));
      if (din_q.size() != 0) chk("din_word", rcv_data, din_q.pop_front());
    end
    if (tx_deq_word === 1'b1)      cnt_deq++;
    if (key_load === 1'b1)         cnt_kl++;
    if (is_encrypt_pulse === 1'b1) begin cnt_enc++; enc_cyc = cyc; end
    if (is_decrypt_pulse === 1'b1) begin cnt_dec++; dec_cyc = cyc; end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_idle();
    HSELx = 0; HTRANS = 2'b00; HADDR = '0; HWRITE = 0; HSIZE = 3'd2; HWDATA = '0;
  endtask

  task automatic st(input int i, input logic [31:0] ad, input bit wr, input logic [31:0] dt,
                    input logic [2:0] sz, input bit er, input logic [31:0] ex);
    t_addr[i] = ad; t_wr[i] = wr; t_data[i] = dt; t_size[i] = sz; t_err[i] = er; t_exp[i] = ex;
  endtask

  // Pipelined AHB master: address phase of the next transfer overlaps the current data phase.
  task automatic run(input int n);
    int a = 0;
    int d = -1;
    int guard = 0;
    bit rdy, stalling;
    rr_log.delete();
    last_waits = 0;
    for (int i = 0; i < n; i++) begin
      if (!t_err[i] && !t_wr[i]) rd_q.push_back(t_exp[i]);
      if (!t_err[i] && t_wr[i] && t_addr[i] >= 32'h40 && t_addr[i] <= 32'h4C) din_q.push_back(t_data[i]);
    end
    while ((a < n || d >= 0) && guard < 100) begin
      if (a < n) begin
        HSELx  = 1;
        HTRANS = (a > 0 && t_addr[a] == t_addr[a-1] + 32'd4) ? 2'b11 : 2'b10;
        HADDR  = t_addr[a]; HWRITE = t_wr[a]; HSIZE = t_size[a];
      end else begin
        HSELx = 0; HTRANS = 2'b00; HADDR = '0; HWRITE = 0; HSIZE = 3'd2;
      end
      HWDATA = (d >= 0 && t_wr[d]) ? t_data[d] : 32'h0;
      stalling = (d >= 0 && d == stall_idx && stall_left > 0);
      rcv_fifo_empty = !(stalling && stall_sel == 0);
      rcv_fifo_full  = stalling && stall_sel == 1;
      tx_fifo_empty  = stalling && stall_sel == 2;
      @(negedge HCLK);
      rdy = HREADY;
      rr_log.push_back({HREADY, HRESP});
      if (!rdy) last_waits++;
      if (stalling && hold_chk) chk("key_w1_hold", key_out[95:64], hold_exp);
      if (rdy && d >= 0 && !t_wr[d] && !t_err[d]) chk("hrdata", HRDATA, rd_q.pop_front());
      tick();
      if (stalling) stall_left--;
      if (rdy) begin
        d = (a < n) ? a : -1;
        if (a < n) a++;
      end
      guard++;
    end
    chk("run_bounded", 256'(guard < 100), 256'(1));
    drive_idle();
    rcv_fifo_empty = 1; rcv_fifo_full = 0; tx_fifo_empty = 0;
    stall_idx = -1; hold_chk = 0;
  endtask

  initial begin
    HRESETn = 1'b1;
    drive_idle();
    status = 8'hA5; data_out = 32'h0;
    rcv_fifo_full = 0; rcv_fifo_empty = 1; tx_fifo_empty = 0;
    #2 HRESETn = 1'b0;
    repeat (3) tick();
    @(negedge HCLK);
    chk("rst_hready", HREADY, 1'b1);
    chk("rst_hresp", HRESP, 1'b0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_key", key_out, 128'h0);
    chk("rst_rcv_data", rcv_data, 32'h0);
    chk("rst_strobes", {rcv_enq_word, tx_deq_word, key_load, is_encrypt_pulse, is_decrypt_pulse}, 5'b0);
    tick();
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("post_rst_hready", HREADY, 1'b1);
    tick();

    // Idle transfer and deselected nonseq: no side effects
    HSELx = 1; HTRANS = 2'b00; HADDR = 32'h40; HWRITE = 1;
    tick();
    HSELx = 0; HTRANS = 2'b10;
    @(negedge HCLK);
    chk("idle_hready", HREADY, 1'b1);
    tick();
    drive_idle();
    tick();
    chk("idle_no_enq", cnt_enq, 0);

    // Key burst with empty RX FIFO: zero waits, one key_load
    st(0, 32'h10, 1, 32'h41424344, 3'd2, 0, 0);
    st(1, 32'h14, 1, 32'h45464748, 3'd2, 0, 0);
    st(2, 32'h18, 1, 32'h494A4B4C, 3'd2, 0, 0);
    st(3, 32'h1C, 1, 32'h4D4E4F50, 3'd2, 0, 0);
    run(4);
    chk("key_burst_waits", last_waits, 0);
    tick(); tick();
    chk("key_burst_value", key_out, 128'h41424344_45464748_494A4B4C_4D4E4F50);
    chk("key_load_once", cnt_kl, 1);

    // RX FIFO not empty for 3 cycles during write to key word 1
    st(0, 32'h14, 1, 32'h11223344, 3'd2, 0, 0);
    stall_idx = 0; stall_left = 3; stall_sel = 0;
    hold_chk = 1; hold_exp = 32'h45464748;
    run(1);
    chk("key_stall_waits", last_waits, 3);
    tick();
    chk("key_w1_updated", key_out, 128'h41424344_11223344_494A4B4C_4D4E4F50);
    chk("key_load_not_w1", cnt_kl, 1);

    // Key burst pipelined into a 4-word DATA_IN burst
    enq_cyc.delete();
    c0 = cnt_enq;
    st(0, 32'h10, 1, 32'h00112233, 3'd2, 0, 0);
    st(1, 32'h14, 1, 32'h44556677, 3'd2, 0, 0);
    st(2, 32'h18, 1, 32'h8899AABB, 3'd2, 0, 0);
    st(3, 32'h1C, 1, 32'hCCDDEEFF, 3'd2, 0, 0);
    for (int i = 0; i < 4; i++) st(4 + i, 32'h40 + 32'(4 * i), 1, 32'h0BAD0001 + 32'(i), 3'd2, 0, 0);
    run(8);
    tick();
    chk("kd_waits", last_waits, 0);
    chk("kd_enq_count", cnt_enq - c0, 4);
    chk("kd_enq_nogap", 256'(enq_cyc.size() == 4 && enq_cyc[3] - enq_cyc[0] == 3), 256'(1));
    chk("kd_key", key_out, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("kd_key_load", cnt_kl, 2);

    // DATA_IN stalls while RX FIFO full
    c0 = cnt_enq;
    st(0, 32'h44, 1, 32'h5A5A0044, 3'd2, 0, 0);
    stall_idx = 0; stall_left = 2; stall_sel = 1;
    run(1);
    chk("din_full_waits", last_waits, 2);
    chk("din_full_enq", cnt_enq - c0, 1);

    // DATA_OUT stalls while TX FIFO empty, then returns data_out with one dequeue
    data_out = 32'hCAFEF00D;
    c0 = cnt_deq;
    st(0, 32'h80, 0, 32'h0, 3'd2, 0, 32'hCAFEF00D);
    stall_idx = 0; stall_left = 2; stall_sel = 2;
    run(1);
    chk("dout_waits", last_waits, 2);
    chk("dout_deq", cnt_deq - c0, 1);

    // Status read, then DEC and ENC commands
    st(0, 32'h00, 0, 32'h0, 3'd2, 0, 32'h000000A5);
    st(1, 32'h08, 1, 32'h0, 3'd2, 0, 0);
    st(2, 32'h04, 1, 32'h0, 3'd2, 0, 0);
    run(3);
    tick(); tick();
    chk("cmd_waits", last_waits, 0);
    chk("dec_count", cnt_dec, 1);
    chk("enc_count", cnt_enc, 1);
    chk("dec_before_enc", 256'(dec_cyc + 1 == enc_cyc), 256'(1));
    @(negedge HCLK);
    chk("hrdata_idle_zero", HRDATA, 32'h0);
    tick();

    // Error responses: unmapped, misaligned, wrong direction, bad size
    c0 = cnt_enq; c1 = cnt_deq; c2 = cnt_kl; c3 = cnt_enc; c4 = cnt_dec;
    st(0, 32'h128, 1, 32'h12345678, 3'd2, 1, 0);
    run(1);
    chk("err_unmapped_seq", {rr_log.size() == 3, rr_log[0], rr_log[1], rr_log[2]}, {1'b1, 2'b10, 2'b01, 2'b11});
    st(0, 32'h41, 1, 32'h1, 3'd2, 1, 0);
    run(1);
    chk("err_misaligned", {rr_log.size() == 3, rr_log[1], rr_log[2]}, {1'b1, 2'b01, 2'b11});
    st(0, 32'h04, 0, 32'h0, 3'd2, 1, 0);
    run(1);
    chk("err_wrong_dir", {rr_log.size() == 3, rr_log[1], rr_log[2]}, {1'b1, 2'b01, 2'b11});
    st(0, 32'h40, 1, 32'h2, 3'd0, 1, 0);
    run(1);
    chk("err_bad_size", {rr_log.size() == 3, rr_log[1], rr_log[2]}, {1'b1, 2'b01, 2'b11});
    tick();
    chk("err_no_strobes", {cnt_enq - c0, cnt_deq - c1, cnt_kl - c2, cnt_enc - c3, cnt_dec - c4}, 160'h0);
    chk("err_key_kept", key_out, 128'h00112233_44556677_8899AABB_CCDDEEFF);

    // Reset in the middle of a stalled DATA_IN write abandons it
    c0 = cnt_enq;
    rcv_fifo_full = 1;
    HSELx = 1; HTRANS = 2'b10; HADDR = 32'h48; HWRITE = 1; HSIZE = 3'd2;
    tick();
    drive_idle();
    HWDATA = 32'h77777777;
    @(negedge HCLK);
    chk("mid_stall_hready", HREADY, 1'b0);
    #1 HRESETn = 1'b0;
    #1;
    chk("mid_rst_hready", HREADY, 1'b1);
    chk("mid_rst_enq", rcv_enq_word, 1'b0);
    chk("mid_rst_key", key_out, 128'h0);
    tick();
    HRESETn = 1'b1;
    rcv_fifo_full = 0;
    tick();
    chk("mid_rst_no_enq", cnt_enq - c0, 0);
    st(0, 32'h00, 0, 32'h0, 3'd2, 0, 32'h000000A5);
    st(1, 32'h4C, 1, 32'hFEEDBEEF, 3'd2, 0, 0);
    run(2);
    tick();
    chk("post_rst_enq", cnt_enq - c0, 1);
    chk("din_q_drained", din_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
